pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline hazard and branch controller for the PIGRO core, between fetch/read and the execution stage. Detects read-after-write hazards between the instruction in the read stage and the destinations still in flight in EX and write-back, stalls fetch/read and injects NOP bubbles into EX while they persist. Turns a taken branch from EX into a PC load plus a fixed-length flush. Keeps saturating stall/flush counters and a sticky stall-watchdog flag.

## Interface
- FLUSH_CYCLES, 2, cycles of flush after a taken branch (1..7)
- MAX_STALL, 15, consecutive stall cycles before `hazard_err` sets (1..255)
- CNT_W, 16, width of performance counters

- clk  in  1  clock, all state on posedge
- rst  in  1  reset; one clock, synchronous, active-high
- id_valid  in  1  read stage holds a real instruction
- id_opcode  in  5  read-stage opcode (opcodes.vh encoding)
- id_src_a, id_src_b  in  4  read-stage source register addresses
- id_isimm  in  1  read-stage immediate flag
- ex_valid  in  1  EX holds a real instruction
- ex_opcode  in  5  EX opcode
- ex_dest  in  4  EX destination register
- wb_valid  in  1  write-back holds a real instruction
- wb_opcode  in  5  write-back opcode
- wb_dest  in  4  write-back destination register
- br_taken  in  1  EX branch-taken flag (fetch_flag)
- br_target  in  5  EX branch target
- fetch_stall  out  1  hold PC and fetch register
- read_stall  out  1  hold read-stage register
- ex_bubble  out  1  load NOP into EX instead of read-stage instruction
- flush_read  out  1  invalidate read-stage register
- pc_load  out  1  one-cycle PC load strobe
- pc_load_val  out  5  PC value to load
- hazard_err  out  1  sticky watchdog flag
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of taken branches

## Operation
- Writer: valid and (`NOP` < opcode <= `ARSH` or opcode == `LDW`). `STR`, `CMP`, branches, `NOP` never write.
- Source use by id_opcode: arith/logic → src_a, plus src_b if id_isimm=0; `STR`, `LDW` → src_a if id_isimm=0; `CMP`, `BRQ`/`BRG`/`BRS` → src_a and src_b; `NOP` → none.
- hazard = id_valid and a used source equals ex_dest (EX is writer) or wb_dest (WB is writer). All 16 registers compared, r0 included. No forwarding.
- FSM states: RUN, STALL, FLUSH.
  - RUN: br_taken → pc_load=1, pc_load_val=br_target, flush_read=1, ex_bubble=1, next FLUSH. Else hazard → fetch_stall=read_stall=ex_bubble=1, next STALL. Else all 0, stay.
  - STALL: br_taken → same as RUN branch case (branch wins over hazard). Else hazard → stall outputs asserted, stay. Else outputs 0, next RUN.
  - FLUSH: flush_read=1, ex_bubble=1, fetch_stall=read_stall=0, pc_load=0; br_taken and hazard ignored. Leaves to RUN after FLUSH_CYCLES total flush cycles, the branch cycle included.
- pc_load_val is br_target while pc_load=1, else 0.
- stall_cnt +1 on each cycle fetch_stall=1. flush_cnt +1 on each pc_load. Both saturate at all-ones.
- Watchdog counts consecutive cycles with fetch_stall=1 and clears on any cycle without it. On reaching MAX_STALL, hazard_err sets and stays set until rst. Stalling continues regardless.

## Timing
- Control outputs are combinational from the inputs and registered state (same-cycle Mealy), so the hold/bubble takes effect at the next posedge. State, counters, watchdog and hazard_err are registered.
- Reset: while rst=1 all outputs are forced 0. The clocked reset edge gives state=RUN, counters=0, watchdog=0, hazard_err=0. rst mid-STALL or mid-FLUSH aborts the sequence immediately.
- Hazard-to-stall latency 0 cycles. Stall release is the first cycle the hazard is gone.
- Branch: pc_load exactly one cycle; flush_read/ex_bubble high for exactly FLUSH_CYCLES consecutive cycles.
- A hazard in the last FLUSH cycle is honoured in the following RUN cycle.

## Test plan
- Reset with rst=1 for 2 cycles, all inputs 0 → all outputs 0, counters 0, state RUN.
- ex: `ADD`, valid, dest=3; id: `ADD` src_a=3, isimm=0 for 2 cycles, then ex goes `NOP` → fetch_stall/read_stall/ex_bubble=1 for 2 cycles then 0, stall_cnt=2.
- id `ADD` src_b=5, isimm=1; ex `ADD` dest=5 → no stall. Same with isimm=0 → stall. ex `CMP` dest=5 → no stall.
- RUN plus hazard on r2 and br_taken=1, br_target=17 in the same cycle → pc_load=1, pc_load_val=17, no fetch_stall, flush 2 cycles (FLUSH_CYCLES=2), flush_cnt=1. A second br_taken inside FLUSH is ignored.
- MAX_STALL=4, hazard held 6 cycles → hazard_err rises after the 4th stall cycle and stays 1 after the hazard clears, until rst.
- CNT_W=3, 10 stall cycles → stall_cnt saturates at 7.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: RAW hazard stall, taken-branch PC load/flush, stall/flush counters and stall watchdog
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_STALL    = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_opcode,
    input  logic [3:0]       id_src_a,
    input  logic [3:0]       id_src_b,
    input  logic             id_isimm,
    input  logic             ex_valid,
    input  logic [4:0]       ex_opcode,
    input  logic [3:0]       ex_dest,
    input  logic             wb_valid,
    input  logic [4:0]       wb_opcode,
    input  logic [3:0]       wb_dest,
    input  logic             br_taken,
    input  logic [4:0]       br_target,
    output logic             fetch_stall,
    output logic             read_stall,
    output logic             ex_bubble,
    output logic             flush_read,
    output logic             pc_load,
    output logic [4:0]       pc_load_val,
    output logic             hazard_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    // opcode encoding: NOP, arith/logic block ADD..ARSH, then memory, compare and branches
    localparam logic [4:0] NOP  = 5'd0;
    localparam logic [4:0] ARSH = 5'd9;
    localparam logic [4:0] LDW  = 5'd10;
    localparam logic [4:0] STR  = 5'd11;
    localparam logic [4:0] CMP  = 5'd12;
    localparam logic [4:0] BRQ  = 5'd13;
    localparam logic [4:0] BRG  = 5'd14;
    localparam logic [4:0] BRS  = 5'd15;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [2:0]       fl_q, fl_d;
    logic [7:0]       wd_q;
    logic             err_q;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             ex_wr, wb_wr, use_a, use_b, hazard;
    logic             fs, bub, fr, pl;

    // source usage and producer classification, then RAW match against EX and WB
    always_comb begin
        ex_wr  = ex_valid && ((ex_opcode > NOP && ex_opcode <= ARSH) || ex_opcode == LDW);
        wb_wr  = wb_valid && ((wb_opcode > NOP && wb_opcode <= ARSH) || wb_opcode == LDW);
        use_a  = (id_opcode > NOP && id_opcode <= ARSH) || ((id_opcode == STR || id_opcode == LDW) && !id_isimm) ||
                 id_opcode == CMP || id_opcode == BRQ || id_opcode == BRG || id_opcode == BRS;
        use_b  = ((id_opcode > NOP && id_opcode <= ARSH) && !id_isimm) ||
                 id_opcode == CMP || id_opcode == BRQ || id_opcode == BRG || id_opcode == BRS;
        hazard = id_valid && ((use_a && ((ex_wr && id_src_a == ex_dest) || (wb_wr && id_src_a == wb_dest))) ||
                              (use_b && ((ex_wr && id_src_b == ex_dest) || (wb_wr && id_src_b == wb_dest))));
    end

    // next state and Mealy control; a taken branch outranks a hazard outside FLUSH
    always_comb begin
        state_d = state_q;
        fl_d    = fl_q;
        fs      = 1'b0;
        bub     = 1'b0;
        fr      = 1'b0;
        pl      = 1'b0;
        case (state_q)
            FLUSH: begin
                fr      = 1'b1;
                bub     = 1'b1;
                fl_d    = fl_q + 3'd1;
                state_d = (fl_q >= 3'(FLUSH_CYCLES - 1)) ? RUN : FLUSH;
            end
            default: begin
                if (br_taken) begin
                    pl      = 1'b1;
                    fr      = 1'b1;
                    bub     = 1'b1;
                    fl_d    = 3'd1;
                    state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                end else if (hazard) begin
                    fs      = 1'b1;
                    bub     = 1'b1;
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    // outputs are forced low for the whole reset cycle
    always_comb begin
        fetch_stall = !rst && fs;
        read_stall  = !rst && fs;
        ex_bubble   = !rst && bub;
        flush_read  = !rst && fr;
        pc_load     = !rst && pl;
        pc_load_val = (!rst && pl) ? br_target : 5'd0;
        hazard_err  = !rst && err_q;
        stall_cnt   = rst ? '0 : stall_q;
        flush_cnt   = rst ? '0 : flush_q;
    end

    // state, flush length, saturating counters and the sticky stall watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fl_q    <= 3'd0;
            wd_q    <= 8'd0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            fl_q    <= fl_d;
            wd_q    <= fs ? ((int'(wd_q) >= MAX_STALL) ? wd_q : wd_q + 8'd1) : 8'd0;
            err_q   <= err_q || (fs && int'(wd_q) + 1 >= MAX_STALL);
            if (fs && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
            if (pl && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed literal checks plus randomized run against a flush-countdown reference model
module tb_pipe_ctrl;
    localparam int FC  = 2;
    localparam int MS  = 4;
    localparam int CW  = 3;
    localparam int SAT = (1 << CW) - 1;
    localparam logic [4:0] NOP = 5'd0, ADD = 5'd1, LDW = 5'd10, STR = 5'd11, CMP = 5'd12;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_isimm, ex_valid, wb_valid, br_taken;
    logic [4:0] id_opcode, ex_opcode, wb_opcode, br_target;
    logic [3:0] id_src_a, id_src_b, ex_dest, wb_dest;
    logic fetch_stall, read_stall, ex_bubble, flush_read, pc_load, hazard_err;
    logic [4:0] pc_load_val;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    int m_fl = 0;
    int m_wd = 0;
    int m_sc = 0;
    int m_fc = 0;
    bit m_err = 0;

    pipe_ctrl #(.FLUSH_CYCLES(FC), .MAX_STALL(MS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_src_a(id_src_a), .id_src_b(id_src_b), .id_isimm(id_isimm),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_dest(ex_dest),
        .wb_valid(wb_valid), .wb_opcode(wb_opcode), .wb_dest(wb_dest),
        .br_taken(br_taken), .br_target(br_target),
        .fetch_stall(fetch_stall), .read_stall(read_stall), .ex_bubble(ex_bubble), .flush_read(flush_read),
        .pc_load(pc_load), .pc_load_val(pc_load_val), .hazard_err(hazard_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit writes(input bit v, input int op);
        return v && ((op >= 1 && op <= 9) || op == 10);
    endfunction

    function automatic bit hits(input int r);
        return (writes(ex_valid, ex_opcode) && r == ex_dest) || (writes(wb_valid, wb_opcode) && r == wb_dest);
    endfunction

    function automatic bit model_hazard();
        int op = id_opcode;
        bit ua, ub;
        ua = (op >= 1 && op <= 9) || ((op == 10 || op == 11) && !id_isimm) || (op >= 12 && op <= 15);
        ub = ((op >= 1 && op <= 9) && !id_isimm) || (op >= 12 && op <= 15);
        return id_valid && ((ua && hits(id_src_a)) || (ub && hits(id_src_b)));
    endfunction

    always @(negedge clk) begin
        automatic bit hz = model_hazard();
        automatic bit e_fs = 0, e_bub = 0, e_fr = 0, e_pl = 0;
        automatic int e_pv = 0;
        if (!rst) begin
            if (m_fl > 0) begin
                e_fr = 1; e_bub = 1;
            end else if (br_taken) begin
                e_pl = 1; e_pv = br_target; e_fr = 1; e_bub = 1;
            end else if (hz) begin
                e_fs = 1; e_bub = 1;
            end
        end
        chk("fetch_stall", fetch_stall, e_fs);
        chk("read_stall", read_stall, e_fs);
        chk("ex_bubble", ex_bubble, e_bub);
        chk("flush_read", flush_read, e_fr);
        chk("pc_load", pc_load, e_pl);
        chk("pc_load_val", pc_load_val, e_pv);
        chk("hazard_err", hazard_err, rst ? 0 : m_err);
        chk("stall_cnt", stall_cnt, rst ? 0 : m_sc);
        chk("flush_cnt", flush_cnt, rst ? 0 : m_fc);
        if (rst) begin
            m_fl <= 0; m_wd <= 0; m_sc <= 0; m_fc <= 0; m_err <= 0;
        end else begin
            m_fl  <= (m_fl > 0) ? m_fl - 1 : (br_taken ? FC - 1 : 0);
            m_fc  <= (e_pl && m_fc < SAT) ? m_fc + 1 : m_fc;
            m_sc  <= (e_fs && m_sc < SAT) ? m_sc + 1 : m_sc;
            m_wd  <= e_fs ? m_wd + 1 : 0;
            m_err <= m_err || (e_fs && m_wd + 1 >= MS);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; id_valid = 0; id_opcode = NOP; id_src_a = 0; id_src_b = 0; id_isimm = 0;
        ex_valid = 0; ex_opcode = NOP; ex_dest = 0; wb_valid = 0; wb_opcode = NOP; wb_dest = 0;
        br_taken = 0; br_target = 0;
        @(negedge clk);
        chk("lit_rst_fetch_stall", fetch_stall, 0);
        chk("lit_rst_pc_load", pc_load, 0);
        step();
        step();
        rst = 0;
        @(negedge clk);
        chk("lit_post_rst_stall_cnt", stall_cnt, 0);
        chk("lit_post_rst_flush_cnt", flush_cnt, 0);
        chk("lit_post_rst_err", hazard_err, 0);
        step();
        ex_valid = 1; ex_opcode = ADD; ex_dest = 3;
        id_valid = 1; id_opcode = ADD; id_src_a = 3; id_src_b = 7; id_isimm = 0;
        repeat (2) begin
            @(negedge clk);
            chk("lit_raw_fetch_stall", fetch_stall, 1);
            chk("lit_raw_read_stall", read_stall, 1);
            chk("lit_raw_ex_bubble", ex_bubble, 1);
            step();
        end
        ex_opcode = NOP;
        @(negedge clk);
        chk("lit_release_fetch_stall", fetch_stall, 0);
        chk("lit_release_ex_bubble", ex_bubble, 0);
        chk("lit_release_stall_cnt", stall_cnt, 2);
        step();
        ex_opcode = ADD; ex_dest = 5; id_src_a = 1; id_src_b = 5; id_isimm = 1;
        @(negedge clk);
        chk("lit_imm_no_stall", fetch_stall, 0);
        step();
        id_isimm = 0;
        @(negedge clk);
        chk("lit_srcb_stall", fetch_stall, 1);
        step();
        ex_opcode = CMP;
        @(negedge clk);
        chk("lit_cmp_no_stall", fetch_stall, 0);
        step();
        ex_opcode = ADD; ex_dest = 2; id_src_a = 2; id_isimm = 1; br_taken = 1; br_target = 17;
        @(negedge clk);
        chk("lit_br_pc_load", pc_load, 1);
        chk("lit_br_pc_load_val", pc_load_val, 17);
        chk("lit_br_no_stall", fetch_stall, 0);
        chk("lit_br_flush_read", flush_read, 1);
        step();
        br_target = 9;
        @(negedge clk);
        chk("lit_flush2_pc_load", pc_load, 0);
        chk("lit_flush2_pc_load_val", pc_load_val, 0);
        chk("lit_flush2_flush_read", flush_read, 1);
        chk("lit_flush2_ex_bubble", ex_bubble, 1);
        chk("lit_flush2_flush_cnt", flush_cnt, 1);
        step();
        br_taken = 0;
        @(negedge clk);
        chk("lit_post_flush_stall", fetch_stall, 1);
        chk("lit_post_flush_flush_read", flush_read, 0);
        chk("lit_post_flush_flush_cnt", flush_cnt, 1);
        step();
        ex_valid = 0;
        @(negedge clk);
        chk("lit_stall_cnt_4", stall_cnt, 4);
        step();
        ex_valid = 1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("lit_wd_fetch_stall", fetch_stall, 1);
            chk("lit_wd_hazard_err", hazard_err, (i >= 5) ? 1 : 0);
            step();
        end
        ex_valid = 0;
        @(negedge clk);
        chk("lit_err_sticky", hazard_err, 1);
        chk("lit_stall_cnt_sat", stall_cnt, 7);
        step();
        rst = 1;
        @(negedge clk);
        chk("lit_rst_forces_err", hazard_err, 0);
        step();
        rst = 0;
        @(negedge clk);
        chk("lit_rst_clears_err", hazard_err, 0);
        chk("lit_rst_clears_cnt", stall_cnt, 0);
        step();
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(199) == 0);
            id_valid  = ($urandom_range(7) != 0);
            id_opcode = 5'($urandom_range(17));
            id_src_a  = 4'($urandom_range(3));
            id_src_b  = 4'($urandom_range(3));
            id_isimm  = 1'($urandom_range(1));
            ex_valid  = ($urandom_range(3) != 0);
            ex_opcode = 5'($urandom_range(17));
            ex_dest   = 4'($urandom_range(3));
            wb_valid  = ($urandom_range(3) != 0);
            wb_opcode = 5'($urandom_range(17));
            wb_dest   = 4'($urandom_range(3));
            br_taken  = ($urandom_range(9) == 0);
            br_target = 5'($urandom_range(31));
            step();
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
